// File: rtl/sha256_padder_if.sv
// Padder-facing bundle: message input stream, scheduler load port and
// block valid/ack handshake toward the compression controller.
interface sha256_padder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [1:0]  in_bytes;
  logic        core_idle;
  logic [31:0] msg_word_out;
  logic [3:0]  msg_word_addr;
  logic        msg_word_we;
  logic        block_first;
  logic        block_final;
  logic        block_valid;
  logic        block_ack;

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, core_idle, block_ack,
    output in_ready, msg_word_out, msg_word_addr, msg_word_we,
           block_first, block_final, block_valid
  );

  modport master (
    output in_valid, in_data, in_last, in_bytes, core_idle, block_ack,
    input  in_ready, msg_word_out, msg_word_addr, msg_word_we,
           block_first, block_final, block_valid
  );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: buffers one 512-bit block, appends 0x80/zero/length
// padding, bursts the block into the scheduler and hands it off via valid/ack.
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic            clk,
  input  logic            reset,
  sha256_padder_if.slave  bus
);

  typedef enum logic [2:0] {
    S_FILL, S_PAD, S_READY, S_FLUSH, S_WAIT_ACK
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   bitcnt_q, bitcnt_d;
  logic               first_q, first_d;
  logic               pend_q, pend_d;
  logic               extra_q, extra_d;
  logic               final_q, final_d;
  logic [15:0][31:0]  mem_q;
  logic               mem_we;
  logic [31:0]        mem_wdata;
  logic [2:0]         nbytes;
  logic [31:0]        last_word;

  // Byte count of the final word and its marker-inserted form.
  always_comb begin
    nbytes    = (bus.in_bytes == 2'd0) ? 3'd4 : {1'b0, bus.in_bytes};
    last_word = bus.in_data;
    case (bus.in_bytes)
      2'd1:    last_word = {bus.in_data[31:24], 8'h80, 16'h0};
      2'd2:    last_word = {bus.in_data[31:16], 8'h80, 8'h0};
      2'd3:    last_word = {bus.in_data[31:8], 8'h80};
      default: last_word = bus.in_data;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bitcnt_d  = bitcnt_q;
    first_d   = first_q;
    pend_d    = pend_q;
    extra_d   = extra_q;
    final_d   = final_q;
    mem_we    = 1'b0;
    mem_wdata = 32'h0;
    case (state_q)
      S_FILL: begin
        if (bus.in_valid) begin
          mem_we = 1'b1;
          idx_d  = idx_q + 4'd1;
          if (!bus.in_last) begin
            mem_wdata = bus.in_data;
            bitcnt_d  = bitcnt_q + LEN_W'(32);
            if (idx_q == 4'd15) begin
              state_d = S_READY;
              final_d = 1'b0;
            end
          end else begin
            mem_wdata = last_word;
            bitcnt_d  = bitcnt_q + LEN_W'({nbytes, 3'b000});
            pend_d    = (nbytes == 3'd4);
            // Length needs slots 14/15 free after the marker, else an extra block.
            extra_d   = (nbytes == 3'd4) ? (idx_q >= 4'd13) : (idx_q >= 4'd14);
            final_d   = 1'b0;
            state_d   = (idx_q == 4'd15) ? S_READY : S_PAD;
          end
        end
      end
      S_PAD: begin
        mem_we = 1'b1;
        idx_d  = idx_q + 4'd1;
        if (pend_q) begin
          mem_wdata = 32'h8000_0000;
          pend_d    = 1'b0;
        end else if (!extra_q && idx_q == 4'd14) begin
          mem_wdata = bitcnt_q[LEN_W-1 -: 32];
        end else if (!extra_q && idx_q == 4'd15) begin
          mem_wdata = bitcnt_q[31:0];
        end
        if (idx_q == 4'd15) begin
          state_d = S_READY;
          final_d = !extra_q;
        end
      end
      S_READY: begin
        if (bus.core_idle) begin
          state_d = S_FLUSH;
          idx_d   = 4'd0;
        end
      end
      S_FLUSH: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (bus.block_ack) begin
          first_d = 1'b0;
          idx_d   = 4'd0;
          if (extra_q) begin
            extra_d = 1'b0;
            state_d = S_PAD;
          end else if (final_q) begin
            first_d  = 1'b1;
            bitcnt_d = '0;
            state_d  = S_FILL;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FILL;
      idx_q    <= 4'd0;
      bitcnt_q <= '0;
      first_q  <= 1'b1;
      pend_q   <= 1'b0;
      extra_q  <= 1'b0;
      final_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      bitcnt_q <= bitcnt_d;
      first_q  <= first_d;
      pend_q   <= pend_d;
      extra_q  <= extra_d;
      final_q  <= final_d;
    end
  end

  // Block buffer carries no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= mem_wdata;
  end

  logic flush_act, wait_act;
  assign flush_act         = (state_q == S_FLUSH) && !reset;
  assign wait_act          = (state_q == S_WAIT_ACK) && !reset;
  assign bus.in_ready      = (state_q == S_FILL) && !reset;
  assign bus.msg_word_we   = flush_act;
  assign bus.msg_word_addr = flush_act ? idx_q : 4'd0;
  assign bus.msg_word_out  = flush_act ? mem_q[idx_q] : 32'h0;
  assign bus.block_valid   = wait_act;
  assign bus.block_first   = wait_act && first_q;
  assign bus.block_final   = wait_act && final_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Randomized bench for sha256_padder against a byte-level padding model.
module tb_sha256_padder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sha256_padder_if bus();
  sha256_padder dut (.clk(clk), .reset(reset), .bus(bus));

  int   vec_cnt = 0;
  int   err_cnt = 0;
  bit   idle_rand = 1'b0;
  logic idle_man = 1'b1;
  logic rnd_idle = 1'b1;
  assign bus.core_idle = idle_rand ? rnd_idle : idle_man;
  always @(negedge clk) rnd_idle = ($urandom_range(0, 3) != 0);

  logic [7:0] msg_q[$];
  logic [7:0] pad_q[$];
  int         msg_len;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference padding: msg || 0x80 || zeros || 64-bit big-endian bit length.
  task automatic build(input int len);
    logic [63:0] bits;
    msg_len = len;
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
    pad_q = msg_q;
    pad_q.push_back(8'h80);
    while (pad_q.size() % 64 != 56) pad_q.push_back(8'h00);
    bits = 64'(len) * 64'd8;
    for (int i = 7; i >= 0; i--) pad_q.push_back(bits[i*8 +: 8]);
  endtask

  task automatic send_msg();
    int nw;
    logic [31:0] word;
    nw = (msg_len + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      int t;
      for (int b = 0; b < 4; b++)
        word[31-8*b -: 8] = (4*w + b < msg_len) ? msg_q[4*w + b] : 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = word;
      bus.in_last  = (w == nw - 1);
      bus.in_bytes = (w == nw - 1) ? 2'(msg_len % 4) : 2'($urandom_range(0, 3));
      t = 0;
      while (!bus.in_ready && t < 1000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 1000) begin
        chk("in_ready_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic consume();
    int nblk;
    nblk = pad_q.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      int t;
      t = 0;
      while (!bus.msg_word_we && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 2000) begin
        chk("we_timeout", 64'd0, 64'd1);
        return;
      end
      for (int k = 0; k < 16; k++) begin
        logic [31:0] ew;
        ew = {pad_q[b*64+4*k], pad_q[b*64+4*k+1], pad_q[b*64+4*k+2], pad_q[b*64+4*k+3]};
        chk("we", 64'(bus.msg_word_we), 64'd1);
        chk("addr", 64'(bus.msg_word_addr), 64'(k));
        chk($sformatf("word len%0d b%0d w%0d", msg_len, b, k), 64'(bus.msg_word_out), 64'(ew));
        @(negedge clk);
      end
      chk("valid_rise", 64'(bus.block_valid), 64'd1);
      chk("we_after", 64'(bus.msg_word_we), 64'd0);
      chk("first", 64'(bus.block_first), 64'(b == 0));
      chk("final", 64'(bus.block_final), 64'(b == nblk - 1));
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("valid_hold", 64'(bus.block_valid), 64'd1);
      end
      bus.block_ack = 1'b1;
      @(negedge clk);
      bus.block_ack = 1'b0;
      chk("valid_drop", 64'(bus.block_valid), 64'd0);
    end
  endtask

  task automatic run_msg(input int len);
    build(len);
    fork
      send_msg();
      consume();
    join
  endtask

  initial begin
    int lens[4];
    int t;
    lens = '{3, 55, 56, 64};
    bus.in_valid = 1'b0; bus.in_data = 32'h0; bus.in_last = 1'b0;
    bus.in_bytes = 2'd0; bus.block_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_we", 64'(bus.msg_word_we), 64'd0);
    chk("rst_valid", 64'(bus.block_valid), 64'd0);
    chk("rst_out", {32'h0, bus.msg_word_out, 4'h0, bus.msg_word_addr}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.in_ready), 64'd1);
    chk("post_rst_first", 64'(bus.block_first), 64'd0);

    idle_rand = 1'b1;
    foreach (lens[i]) run_msg(lens[i]);

    // core_idle held low in READY: no writes, no input acceptance.
    idle_rand = 1'b0;
    @(negedge clk);
    idle_man = 1'b0;
    build(3);
    send_msg();
    repeat (20) @(negedge clk);
    repeat (20) begin
      @(negedge clk);
      chk("idle_we", 64'(bus.msg_word_we), 64'd0);
      chk("idle_ready", 64'(bus.in_ready), 64'd0);
    end
    idle_man = 1'b1;
    @(negedge clk);
    chk("idle_start_we", 64'(bus.msg_word_we), 64'd1);
    chk("idle_start_addr", 64'(bus.msg_word_addr), 64'd0);
    consume();

    // Reset in the middle of a flush abandons the block.
    build(3);
    send_msg();
    t = 0;
    while (!(bus.msg_word_we && bus.msg_word_addr == 4'd7) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("reach_addr7", 64'(t < 200), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_we", 64'(bus.msg_word_we), 64'd0);
    chk("midrst_valid", 64'(bus.block_valid), 64'd0);
    chk("midrst_ready", 64'(bus.in_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", 64'(bus.in_ready), 64'd1);
    run_msg(3);

    idle_rand = 1'b1;
    repeat (12) run_msg($urandom_range(1, 150));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/sha256_padder.md
Name: sha256_padder

Overview:
Upstream stage of message_scheduler. Accepts a message as a stream of big-endian 32-bit words and applies SHA-256 padding: a 0x80 byte, zero fill, and a 64-bit bit length. It buffers each 512-bit block in a 16x32 memory and bursts it into the scheduler load port (message_word_in / message_word_addr / write_enable_in). It then hands the block to the compression controller with a valid/ack handshake.

Parameters:
LEN_W, 64, width of message bit-length counter; fixed by the SHA-256 standard; counter wraps modulo 2^64

Ports:
clk  in  1  clock; all logic posedge
reset  in  1  synchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  padder accepts input word this cycle
in_data  in  32  message word; byte 0 in [31:24]
in_last  in  1  word is the final word of the message
in_bytes  in  2  valid bytes in last word: 0=4, 1=1, 2=2, 3=3 (MSB-aligned); ignored when in_last=0
core_idle  in  1  scheduler/core may be overwritten with a new block
msg_word_out  out  32  to scheduler message_word_in
msg_word_addr  out  4  to scheduler message_word_addr
msg_word_we  out  1  to scheduler write_enable_in
block_first  out  1  block is the first of a message (drives start_new_block); valid with block_valid
block_final  out  1  block is the last of a message; valid with block_valid
block_valid  out  1  block fully written into scheduler, held until block_ack
block_ack  in  1  one-cycle pulse from core; consumes the block

Behaviour:
- Reset (sampled at posedge, overrides everything, including mid-burst): state FILL, idx=0, bit count=0, first_flag=1, pad_pending=0. Outputs: in_ready=0 during the reset cycle, msg_word_we=0, msg_word_out=0, msg_word_addr=0, block_valid=0, block_first=0, block_final=0. A partially written scheduler block is abandoned.
- States: FILL, PAD, READY, FLUSH, WAIT_ACK.
- FILL: in_ready=1. On in_valid&in_ready: buf[idx]<=in_data, bitcnt += 32, idx++.
  - Not last: when idx==15 is written, go to READY.
  - Last: bitcnt += 8*nbytes (nbytes = 4 if in_bytes==0).
    - nbytes<4: write the data word with byte nbytes set to 0x80 and lower bytes zeroed. Upper bytes are kept even if the source data is nonzero below the valid bytes.
    - nbytes==4: write in_data unchanged and mark pad_pending (0x80000000 goes into the next slot).
    - Either way, go to PAD.
- PAD: one word per cycle, in_ready=0.
  - Slot order: 0x80000000 if pending, else 0; zeros up to idx 13; idx 14 = bitcnt[63:32]; idx 15 = bitcnt[31:0].
  - If the 0x80 marker lands at idx 14 or 15 (i.e. the message ends with fewer than 8 free bytes), zero-fill to 15 and set extra_block. The following block is all zeros at 0..13 with length at 14/15.
  - After idx 15 is written, go to READY.
- READY: wait for core_idle=1, then go to FLUSH (no write in the transition cycle).
- FLUSH: 16 consecutive cycles, msg_word_we=1, addr 0..15, data buf[addr]. Not stallable; core_idle is ignored once started. Then go to WAIT_ACK.
- WAIT_ACK: block_valid=1; block_first/block_final are stable. On block_ack:
  - Clear first_flag.
  - If extra_block: go to PAD at idx 0.
  - Else if final: set first_flag=1, bitcnt=0, go to FILL.
  - Else: go to FILL.
  - block_ack outside WAIT_ACK is ignored.
- Latency: the 16th word is accepted at cycle N, READY is at N+1. With core_idle=1 at N+1, writes occur at N+2..N+17 and block_valid rises at N+18.
- Simultaneous in_valid with a non-FILL state: not accepted (in_ready=0). The source holds the data.
- Zero-length messages are not supported.

Test Plan:
- "abc": in_data=0x61626300, in_last=1, in_bytes=3 -> block words 0x61626380, 0x0 x13, 0x00000000, 0x00000018; block_first=1, block_final=1; 16 contiguous we cycles.
- 55-byte message (13 full words + 3-byte last) -> single block; word13 low byte 0x80; w14=0, w15=0x000001B8.
- 56-byte message (14 full words) -> block1: w14=0x80000000, w15=0, block_final=0. Block2: w0..13=0, w15=0x000001C0, block_first=0, block_final=1.
- 64-byte message (16 full words, last=1 on w15) -> block1 is the data only. Block2: w0=0x80000000, w15=0x00000200.
- core_idle held low 20 cycles in READY -> msg_word_we stays 0 and in_ready stays 0. Writes start 1 cycle after core_idle rises. Back-to-back messages give block_first=1 on the second message.
- reset asserted at FLUSH addr 7 -> next cycle msg_word_we=0, block_valid=0. in_ready=1 after reset deasserts. A new "abc" produces a correct single block with length 0x18.
